ball_animator: RTL and testbench
================================

Name: ball_animator

Overview:
- Sits directly upstream of the box drawer: issues erase/draw box commands for the moving basketball, one command at a time, over a go/done handshake.
- On each frame tick it erases the ball at its old position in the background colour, applies velocity, gravity and wall collisions, then draws the ball at its new position.
- A launch request from game control starts the ball.

Parameters:
- BALL_SIZE, 4, ball edge length in pixels; driven on Scalesym.
- BALL_CLR, 3'b110, draw colour.
- BG_CLR, 3'b000, erase colour.
- X_MAX, 160, screen width in pixels.
- Y_MAX, 120, screen height in pixels.
- GRAVITY, 1, added to vy once per frame.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame
- launch  in  1  one-cycle pulse; start ball
- x_init  in  8  launch X, range 0..X_MAX-BALL_SIZE
- y_init  in  7  launch Y, range 0..Y_MAX-BALL_SIZE
- vx_init  in  5  signed launch X velocity
- vy_init  in  6  signed launch Y velocity; positive is down
- Xsym  out  8  box X to drawer
- Ysym  out  7  box Y to drawer
- CLRsym  out  3  box colour to drawer
- Scalesym  out  6  box size to drawer; constant BALL_SIZE
- go  out  1  one-cycle command pulse to drawer
- done  in  1  one-cycle completion pulse from drawer
- ball_active  out  1  ball in flight
- busy  out  1  high in any state except IDLE and WAIT_TICK
- overrun  out  1  one-cycle pulse: frame_tick dropped

Behaviour:
- Reset (asynchronous, active-low): state IDLE. go, busy, ball_active and overrun are 0. Xsym, Ysym and CLRsym are 0. Scalesym is BALL_SIZE. Internal x, y, vx and vy are 0.
- States: IDLE, DRAW_GO, DRAW_WAIT, WAIT_TICK, ERASE_GO, ERASE_WAIT, UPDATE.
- IDLE:
  - On launch, load x, y, vx, vy from the init ports; set ball_active=1; go to DRAW_GO.
  - frame_tick is ignored.
- DRAW_GO:
  - Drive Xsym=x, Ysym=y, CLRsym=BALL_CLR.
  - Pulse go for exactly 1 cycle, then go to DRAW_WAIT.
- DRAW_WAIT:
  - Hold Xsym, Ysym and CLRsym stable until done.
  - On done: if ball_active, go to WAIT_TICK; otherwise go to IDLE (the landed ball stays drawn).
- WAIT_TICK:
  - frame_tick goes to ERASE_GO.
  - launch is ignored.
- ERASE_GO and ERASE_WAIT: same as the draw states, but CLRsym=BG_CLR at the current x, y. On done, go to UPDATE.
- UPDATE, 1 cycle, all arithmetic signed:
  - nx = x + vx (10-bit signed intermediate).
  - ny = y + vy (9-bit signed intermediate).
  - Left wall: nx<0 gives x=0, vx=-vx.
  - Right wall: nx>X_MAX-BALL_SIZE gives x=X_MAX-BALL_SIZE, vx=-vx.
  - Ceiling: ny<0 gives y=0, vy=-vy.
  - Floor: ny>=Y_MAX-BALL_SIZE gives y=Y_MAX-BALL_SIZE, vy=0, ball_active=0 (landing).
  - Otherwise x=nx, y=ny, vy=vy+GRAVITY, saturating at +31.
  - Negating -16 (vx) or -32 (vy) saturates to +15 or +31.
  - Next state: DRAW_GO.
- Latency: go rises 1 cycle after launch or after entry to ERASE_GO. Erase done to the draw go pulse takes 2 cycles (UPDATE, then DRAW_GO).
- overrun: 1-cycle pulse when frame_tick arrives in any state other than WAIT_TICK while ball_active=1. The tick is discarded and does not queue.
- done received outside a *_WAIT state is ignored.
- launch while ball_active is ignored.
- Reset mid-command: the block returns to IDLE immediately. The drawer shares the reset, so no command is left outstanding.

Optional Feature:
- Macro: BALL_BOUNCE_EN.
- Defined: the floor condition sets y=Y_MAX-BALL_SIZE and vy=-(vy>>>1) (arithmetic shift).
  - The ball lands (ball_active=0, vy=0) only if the resulting |vy|<2.
  - Otherwise flight continues.
  - Gravity is not applied on a bounce frame.
- Undefined: floor contact always lands, as described in Behaviour.

Test Plan:
- Reset: assert reset=0 mid-flight -> go=0, ball_active=0, busy=0, CLRsym=0, Scalesym=4; no go pulse after release until launch.
- Launch (x=10, y=20, vx=+2, vy=-3):
  - Expect go with (10,20,CLR=110,Scale=4).
  - After done and a tick: erase at (10,20,CLR=000), then draw at (12,17); internal vy=-2.
- Right wall: x=154, vx=+3, tick -> draw at X=156; next tick draws at X=153.
- Floor landing: y=114, vy=+3, macro off -> draw at Y=116; ball_active falls after that draw's done; a further tick produces no go.
- Bounce, macro on: y=114, vy=+6 -> draw at Y=116, vy=-3, ball_active stays 1. With vy=+3 instead: lands.
- Overrun: frame_tick during DRAW_WAIT -> overrun=1 for one cycle; exactly one erase/draw pair per accepted tick. A done held off for 50 cycles keeps Xsym, Ysym and CLRsym stable.

Source files
------------

// File: rtl/ball_animator.sv
// Basketball animator: issues erase/draw box commands to the box drawer once per frame.
// Define BALL_BOUNCE_EN to make the ball bounce off the floor instead of always landing.
`timescale 1ns/1ps
module ball_animator #(
    parameter int          BALL_SIZE = 4,
    parameter logic [2:0]  BALL_CLR  = 3'b110,
    parameter logic [2:0]  BG_CLR    = 3'b000,
    parameter int          X_MAX     = 160,
    parameter int          Y_MAX     = 120,
    parameter int          GRAVITY   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic [7:0] x_init,
    input  logic [6:0] y_init,
    input  logic [4:0] vx_init,
    input  logic [5:0] vy_init,
    output logic [7:0] Xsym,
    output logic [6:0] Ysym,
    output logic [2:0] CLRsym,
    output logic [5:0] Scalesym,
    output logic       go,
    input  logic       done,
    output logic       ball_active,
    output logic       busy,
    output logic       overrun
);

    localparam logic signed [9:0] XLIM_S = 10'(X_MAX - BALL_SIZE);
    localparam logic signed [8:0] YLIM_S = 9'(Y_MAX - BALL_SIZE);

    typedef enum logic [2:0] {
        IDLE, DRAW_GO, DRAW_WAIT, WAIT_TICK, ERASE_GO, ERASE_WAIT, UPDATE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         x_q, x_d;
    logic [6:0]         y_q, y_d;
    logic signed [4:0]  vx_q, vx_d;
    logic signed [5:0]  vy_q, vy_d;
    logic               active_q, active_d;
    logic [2:0]         clr_q, clr_d;
    logic               overrun_q, overrun_d;

    logic signed [9:0]  nx;
    logic signed [8:0]  ny;
    logic signed [4:0]  vx_neg;
    logic signed [5:0]  vy_neg, vy_grav, vy_half, vy_bnc;
    logic signed [6:0]  vy_sum;

    // Position/velocity candidates; the UPDATE state picks among them.
    always_comb begin
        nx      = $signed({2'b00, x_q}) + $signed({{5{vx_q[4]}}, vx_q});
        ny      = $signed({2'b00, y_q}) + $signed({{3{vy_q[5]}}, vy_q});
        vx_neg  = (vx_q == -5'sd16) ? 5'sd15 : -vx_q;
        vy_neg  = (vy_q == -6'sd32) ? 6'sd31 : -vy_q;
        vy_sum  = $signed({vy_q[5], vy_q}) + 7'(GRAVITY);
        vy_grav = (vy_sum > 7'sd31) ? 6'sd31 : vy_sum[5:0];
        vy_half = vy_q >>> 1;
        vy_bnc  = -vy_half;
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        active_d  = active_q;
        clr_d     = clr_q;
        overrun_d = frame_tick && active_q && (state_q != WAIT_TICK);
        case (state_q)
            IDLE: if (launch) begin
                x_d      = x_init;
                y_d      = y_init;
                vx_d     = $signed(vx_init);
                vy_d     = $signed(vy_init);
                active_d = 1'b1;
                clr_d    = BALL_CLR;
                state_d  = DRAW_GO;
            end
            DRAW_GO:   state_d = DRAW_WAIT;
            DRAW_WAIT: if (done) state_d = active_q ? WAIT_TICK : IDLE;
            WAIT_TICK: if (frame_tick) begin
                clr_d   = BG_CLR;
                state_d = ERASE_GO;
            end
            ERASE_GO:   state_d = ERASE_WAIT;
            ERASE_WAIT: if (done) state_d = UPDATE;
            UPDATE: begin
                if (nx < 0) begin
                    x_d  = 8'd0;
                    vx_d = vx_neg;
                end else if (nx > XLIM_S) begin
                    x_d  = XLIM_S[7:0];
                    vx_d = vx_neg;
                end else begin
                    x_d  = nx[7:0];
                end
                if (ny < 0) begin
                    y_d  = 7'd0;
                    vy_d = vy_neg;
                end else if (ny >= YLIM_S) begin
                    y_d = YLIM_S[6:0];
`ifdef BALL_BOUNCE_EN
                    // A weak rebound (|vy| < 2) counts as landing.
                    if (vy_bnc > -6'sd2 && vy_bnc < 6'sd2) begin
                        vy_d     = 6'sd0;
                        active_d = 1'b0;
                    end else begin
                        vy_d = vy_bnc;
                    end
`else
                    vy_d     = 6'sd0;
                    active_d = 1'b0;
`endif
                end else begin
                    y_d  = ny[6:0];
                    vy_d = vy_grav;
                end
                clr_d   = BALL_CLR;
                state_d = DRAW_GO;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            active_q  <= 1'b0;
            clr_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            active_q  <= active_d;
            clr_q     <= clr_d;
            overrun_q <= overrun_d;
        end
    end

    // x/y only change in launch and UPDATE, so they are stable across each command.
    assign Xsym        = x_q;
    assign Ysym        = y_q;
    assign CLRsym      = clr_q;
    assign Scalesym    = 6'(BALL_SIZE);
    assign go          = (state_q == DRAW_GO) || (state_q == ERASE_GO);
    assign busy        = (state_q != IDLE) && (state_q != WAIT_TICK);
    assign ball_active = active_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_ball_animator.sv
// Directed bench for ball_animator: scoreboard of expected box commands plus a drawer model.
`timescale 1ns/1ps
module tb_ball_animator;

    logic       clk = 1'b0, reset = 1'b0, frame_tick = 1'b0, launch = 1'b0, done = 1'b0;
    logic [7:0] x_init = '0;
    logic [6:0] y_init = '0;
    logic [4:0] vx_init = '0;
    logic [5:0] vy_init = '0;
    logic [7:0] Xsym;
    logic [6:0] Ysym;
    logic [2:0] CLRsym;
    logic [5:0] Scalesym;
    logic       go, ball_active, busy, overrun;

    ball_animator dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .launch(launch),
        .x_init(x_init), .y_init(y_init), .vx_init(vx_init), .vy_init(vy_init),
        .Xsym(Xsym), .Ysym(Ysym), .CLRsym(CLRsym), .Scalesym(Scalesym),
        .go(go), .done(done), .ball_active(ball_active), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_dly = 1;

    localparam logic [2:0] DRAW = 3'b110;
    localparam logic [2:0] ERASE = 3'b000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        cmd_t e;
        e.x = x; e.y = y; e.c = c;
        exp_q.push_back(e);
    endtask

    // Drawer model: score each go against the queue, hold done off, check stability.
    cmd_t       r_exp;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_c;
    bit         r_abort;
    always begin
        @(negedge clk);
        if (go === 1'b1) begin
            chk("go_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                r_exp = exp_q.pop_front();
                chk("cmd_x", 32'(Xsym), 32'(r_exp.x));
                chk("cmd_y", 32'(Ysym), 32'(r_exp.y));
                chk("cmd_clr", 32'(CLRsym), 32'(r_exp.c));
            end
            chk("cmd_scale", 32'(Scalesym), 4);
            r_x = Xsym; r_y = Ysym; r_c = CLRsym;
            @(negedge clk);
            chk("go_width", 32'(go), 0);
            r_abort = 1'b0;
            for (int i = 0; i < done_dly; i++) begin
                @(negedge clk);
                if (!reset) r_abort = 1'b1;
                if (!r_abort) begin
                    chk("hold_x", 32'(Xsym), 32'(r_x));
                    chk("hold_y", 32'(Ysym), 32'(r_y));
                    chk("hold_clr", 32'(CLRsym), 32'(r_c));
                end
            end
            if (!r_abort && reset) begin
                done = 1'b1;
                @(negedge clk);
                done = 1'b0;
            end
        end
    end

    task automatic do_launch(input logic [7:0] x, input logic [6:0] y,
                             input logic [4:0] vx, input logic [5:0] vy);
        @(posedge clk); #1;
        x_init = x; y_init = y; vx_init = vx; vy_init = vy; launch = 1'b1;
        @(posedge clk); #1;
        launch = 1'b0;
    endtask

    task automatic do_tick();
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic quiet(input int budget, input string tag);
        int n = 0;
        while ((busy || done || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < budget), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_go", 32'(go), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_active", 32'(ball_active), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_x", 32'(Xsym), 0);
        chk("rst_y", 32'(Ysym), 0);
        chk("rst_clr", 32'(CLRsym), 0);
        chk("rst_scale", 32'(Scalesym), 4);
        @(negedge clk) reset = 1'b1;

        // Ticks while idle are ignored
        do_tick();
        @(negedge clk);
        chk("idle_tick_overrun", 32'(overrun), 0);
        repeat (5) @(negedge clk);
        chk("idle_tick_busy", 32'(busy), 0);

        // Launch and a short upward trajectory
        push(10, 20, DRAW);
        do_launch(10, 20, 5'd2, 6'h3D);
        @(negedge clk);
        chk("launch_go_lat", 32'(go), 1);
        quiet(100, "launch_draw");
        chk("flight_active", 32'(ball_active), 1);
        push(10, 20, ERASE); push(12, 17, DRAW);
        do_tick();
        @(negedge clk);
        chk("tick_go_lat", 32'(go), 1);
        quiet(100, "tick1");
        push(12, 17, ERASE); push(14, 15, DRAW);
        do_tick();
        quiet(100, "tick2");
        // Launch in flight must not restart the ball
        do_launch(99, 99, 5'd1, 6'd1);
        repeat (5) @(negedge clk);
        chk("launch_ignored_busy", 32'(busy), 0);
        push(14, 15, ERASE); push(16, 14, DRAW);
        do_tick();
        quiet(100, "tick3");

        // Reset in the middle of an erase command
        done_dly = 20;
        push(16, 14, ERASE);
        do_tick();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_go", 32'(go), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_active", 32'(ball_active), 0);
        chk("midrst_clr", 32'(CLRsym), 0);
        chk("midrst_scale", 32'(Scalesym), 4);
        @(negedge clk) reset = 1'b1;
        do_tick();
        @(negedge clk);
        chk("postrst_overrun", 32'(overrun), 0);
        repeat (40) @(negedge clk);
        chk("postrst_busy", 32'(busy), 0);
        done_dly = 1;

        // Right wall
        push(154, 50, DRAW);
        do_launch(154, 50, 5'd3, 6'd0);
        quiet(100, "rwall_launch");
        push(154, 50, ERASE); push(156, 50, DRAW);
        do_tick();
        quiet(100, "rwall_hit");
        push(156, 50, ERASE); push(153, 51, DRAW);
        do_tick();
        quiet(100, "rwall_back");
        do_reset();

        // Left wall and ceiling together
        push(1, 2, DRAW);
        do_launch(1, 2, 5'h1C, 6'h3B);
        quiet(100, "lwall_launch");
        push(1, 2, ERASE); push(0, 0, DRAW);
        do_tick();
        quiet(100, "lwall_hit");
        push(0, 0, ERASE); push(4, 5, DRAW);
        do_tick();
        quiet(100, "lwall_back");
        do_reset();

        // Most negative velocities, gravity saturation, floor at speed
        push(0, 0, DRAW);
        do_launch(0, 0, 5'h10, 6'h20);
        quiet(100, "sat_launch");
        push(0, 0, ERASE);   push(0, 0, DRAW);
        do_tick(); quiet(100, "sat_t1");
        push(0, 0, ERASE);   push(15, 31, DRAW);
        do_tick(); quiet(100, "sat_t2");
        push(15, 31, ERASE); push(30, 62, DRAW);
        do_tick(); quiet(100, "sat_t3");
        push(30, 62, ERASE); push(45, 93, DRAW);
        do_tick(); quiet(100, "sat_t4");
        push(45, 93, ERASE); push(60, 116, DRAW);
        do_tick(); quiet(100, "sat_floor");
`ifdef BALL_BOUNCE_EN
        chk("sat_floor_active", 32'(ball_active), 1);
`else
        chk("sat_floor_active", 32'(ball_active), 0);
`endif
        do_reset();

        // Gentle floor contact always lands
        push(20, 114, DRAW);
        do_launch(20, 114, 5'd0, 6'd3);
        quiet(100, "land_launch");
        push(20, 114, ERASE); push(20, 116, DRAW);
        do_tick();
        quiet(100, "land_draw");
        chk("land_active", 32'(ball_active), 0);
        chk("land_busy", 32'(busy), 0);
        do_tick();
        @(negedge clk);
        chk("land_tick_overrun", 32'(overrun), 0);
        repeat (10) @(negedge clk);
        chk("land_tick_busy", 32'(busy), 0);

        // Harder floor contact: bounces only with the feature enabled
        push(20, 114, DRAW);
        do_launch(20, 114, 5'd0, 6'd6);
        quiet(100, "bnc_launch");
        push(20, 114, ERASE); push(20, 116, DRAW);
        do_tick();
        quiet(100, "bnc_floor");
`ifdef BALL_BOUNCE_EN
        chk("bnc_active", 32'(ball_active), 1);
        push(20, 116, ERASE); push(20, 113, DRAW);
        do_tick();
        quiet(100, "bnc_rise");
`else
        chk("bnc_active", 32'(ball_active), 0);
`endif
        do_reset();

        // Overrun: tick during a draw is dropped, not queued
        done_dly = 5;
        push(50, 50, DRAW);
        do_launch(50, 50, 5'd1, 6'd0);
        @(negedge clk);
        do_tick();
        @(negedge clk);
        chk("overrun_pulse", 32'(overrun), 1);
        @(negedge clk);
        chk("overrun_width", 32'(overrun), 0);
        quiet(100, "overrun_draw");
        repeat (10) @(negedge clk);
        chk("overrun_no_erase", 32'(busy), 0);
        chk("overrun_active", 32'(ball_active), 1);

        // Long done hold: outputs must stay stable throughout
        done_dly = 50;
        push(50, 50, ERASE); push(51, 50, DRAW);
        do_tick();
        quiet(300, "slow_done");

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
